// File: rtl/asrv32_fetch.sv
// Instruction fetch stage: one outstanding request/acknowledge read to instruction
// memory, with misaligned-PC detection and bus timeout.
module asrv32_fetch #(
  parameter logic [31:0] PC_RESET       = 32'h0000_0000,
  parameter logic [31:0] NOP_INST       = 32'h0000_0013,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_en,
  input  logic [31:0] i_pc,
  input  logic        i_flush,
  output logic        o_ireq,
  output logic [31:0] o_iaddr,
  input  logic        i_iack,
  input  logic [31:0] i_inst,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_pc,
  output logic        o_inst_valid,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_busy
);

  localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned LAST_VAL   = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_VAL);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             ireq_q, ireq_d;
  logic [31:0]      iaddr_q, iaddr_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      inst_pc_q, inst_pc_d;
  logic             valid_q, valid_d;
  logic             mis_q, mis_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next-state and registered-output computation
  always_comb begin
    state_d   = state_q;
    ireq_d    = ireq_q;
    iaddr_d   = iaddr_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = 1'b0;
    mis_d     = 1'b0;
    err_d     = 1'b0;
    busy_d    = busy_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (i_fetch_en) begin
          if (i_pc[1:0] != 2'b00) begin
            mis_d = 1'b1;
          end else if (!i_flush) begin
            state_d = S_REQ;
            ireq_d  = 1'b1;
            iaddr_d = i_pc;
            busy_d  = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      S_REQ: begin
        // Flush beats ack, ack beats timeout
        if (i_flush) begin
          state_d = S_IDLE;
          ireq_d  = 1'b0;
          busy_d  = 1'b0;
        end else if (i_iack) begin
          state_d   = S_IDLE;
          ireq_d    = 1'b0;
          busy_d    = 1'b0;
          inst_d    = i_inst;
          inst_pc_d = iaddr_q;
          valid_d   = 1'b1;
        end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
          state_d = S_IDLE;
          ireq_d  = 1'b0;
          busy_d  = 1'b0;
          err_d   = 1'b1;
        end else if (TIMEOUT_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        ireq_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      ireq_q    <= 1'b0;
      iaddr_q   <= PC_RESET;
      inst_q    <= NOP_INST;
      inst_pc_q <= PC_RESET;
      valid_q   <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ireq_q    <= ireq_d;
      iaddr_q   <= iaddr_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
      mis_q     <= mis_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_ireq       = ireq_q;
  assign o_iaddr      = iaddr_q;
  assign o_inst       = inst_q;
  assign o_inst_pc    = inst_pc_q;
  assign o_inst_valid = valid_q;
  assign o_misaligned = mis_q;
  assign o_bus_err    = err_q;
  assign o_busy       = busy_q;

endmodule

// File: tb/tb_asrv32_fetch.sv
// Directed bench for asrv32_fetch: normal, delayed-ack, misaligned, timeout,
// flush and reset-abort fetches with hand-computed expectations.
module tb_asrv32_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [31:0] pc;
  logic        flush;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iack;
  logic [31:0] inst_in;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        misaligned;
  logic        bus_err;
  logic        busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int hi_cnt;

  asrv32_fetch #(
    .PC_RESET      (32'h0000_0000),
    .NOP_INST      (32'h0000_0013),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_fetch_en  (fetch_en),
    .i_pc        (pc),
    .i_flush     (flush),
    .o_ireq      (ireq),
    .o_iaddr     (iaddr),
    .i_iack      (iack),
    .i_inst      (inst_in),
    .o_inst      (inst),
    .o_inst_pc   (inst_pc),
    .o_inst_valid(inst_valid),
    .o_misaligned(misaligned),
    .o_bus_err   (bus_err),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; pc = '0; flush = 1'b0; iack = 1'b0; inst_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ireq", 32'(ireq), 32'd0);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_inst", inst, 32'h0000_0013);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Fetch at 0x0, ack in the first request cycle
    fetch_en = 1'b1; pc = 32'h0;
    tick();
    fetch_en = 1'b0;
    chk("t1_ireq", 32'(ireq), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_valid_early", 32'(inst_valid), 32'd0);
    iack = 1'b1; inst_in = 32'h0050_0093;
    tick();
    iack = 1'b0;
    chk("t1_valid", 32'(inst_valid), 32'd1);
    chk("t1_inst", inst, 32'h0050_0093);
    chk("t1_inst_pc", inst_pc, 32'h0);
    chk("t1_ireq_drop", 32'(ireq), 32'd0);
    tick();
    chk("t1_valid_pulse", 32'(inst_valid), 32'd0);

    // Fetch at 0x104, ack after 5 wait cycles, fetch_en toggling meanwhile
    fetch_en = 1'b1; pc = 32'h0000_0104;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_ireq_wait", 32'(ireq), 32'd1);
      chk("t2_iaddr_wait", iaddr, 32'h0000_0104);
      chk("t2_busy_wait", 32'(busy), 32'd1);
      chk("t2_valid_wait", 32'(inst_valid), 32'd0);
      fetch_en = i[0]; pc = 32'h0000_0200;
      tick();
    end
    chk("t2_ireq_last", 32'(ireq), 32'd1);
    chk("t2_iaddr_last", iaddr, 32'h0000_0104);
    fetch_en = 1'b0; iack = 1'b1; inst_in = 32'h00A0_0113;
    tick();
    iack = 1'b0;
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_inst", inst, 32'h00A0_0113);
    chk("t2_inst_pc", inst_pc, 32'h0000_0104);
    chk("t2_busy_drop", 32'(busy), 32'd0);
    tick();
    chk("t2_no_second_req", 32'(ireq), 32'd0);
    chk("t2_valid_pulse", 32'(inst_valid), 32'd0);

    // Misaligned PC
    fetch_en = 1'b1; pc = 32'h0000_0102;
    tick();
    fetch_en = 1'b0;
    chk("t3_misaligned", 32'(misaligned), 32'd1);
    chk("t3_ireq", 32'(ireq), 32'd0);
    chk("t3_inst_kept", inst, 32'h00A0_0113);
    chk("t3_busy", 32'(busy), 32'd0);
    tick();
    chk("t3_mis_pulse", 32'(misaligned), 32'd0);
    chk("t3_ireq_after", 32'(ireq), 32'd0);

    // Timeout: no ack, request abandoned after 16 cycles
    fetch_en = 1'b1; pc = 32'h0000_0040;
    tick();
    fetch_en = 1'b0;
    hi_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!ireq) break;
      hi_cnt++;
      tick();
    end
    chk("t4_ireq_cycles", 32'(hi_cnt), 32'd16);
    chk("t4_bus_err", 32'(bus_err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_valid", 32'(inst_valid), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(bus_err), 32'd0);
    fetch_en = 1'b1; pc = 32'h0000_0008;
    tick();
    fetch_en = 1'b0;
    chk("t4_refetch_iaddr", iaddr, 32'h0000_0008);
    iack = 1'b1; inst_in = 32'h0010_0073;
    tick();
    iack = 1'b0;
    chk("t4_refetch_valid", 32'(inst_valid), 32'd1);
    chk("t4_refetch_inst", inst, 32'h0010_0073);
    chk("t4_refetch_pc", inst_pc, 32'h0000_0008);

    // Ack in the final timeout cycle wins
    fetch_en = 1'b1; pc = 32'h0000_0050;
    tick();
    fetch_en = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("t5_ireq_final", 32'(ireq), 32'd1);
    iack = 1'b1; inst_in = 32'h0020_0193;
    tick();
    iack = 1'b0;
    chk("t5_valid", 32'(inst_valid), 32'd1);
    chk("t5_no_err", 32'(bus_err), 32'd0);
    chk("t5_inst_pc", inst_pc, 32'h0000_0050);

    // Flush together with ack discards the data
    fetch_en = 1'b1; pc = 32'h0000_0010;
    tick();
    fetch_en = 1'b0;
    iack = 1'b1; flush = 1'b1; inst_in = 32'hDEAD_BEEF;
    tick();
    iack = 1'b0; flush = 1'b0;
    chk("t6_ireq", 32'(ireq), 32'd0);
    chk("t6_no_valid", 32'(inst_valid), 32'd0);
    chk("t6_inst_kept", inst, 32'h0020_0193);
    chk("t6_inst_pc_kept", inst_pc, 32'h0000_0050);
    chk("t6_busy", 32'(busy), 32'd0);

    // Flush in IDLE blocks the start
    fetch_en = 1'b1; flush = 1'b1; pc = 32'h0000_0020;
    tick();
    fetch_en = 1'b0; flush = 1'b0;
    chk("t7_flush_idle", 32'(ireq), 32'd0);

    // Reset mid-request overrides a concurrent ack
    fetch_en = 1'b1; pc = 32'h0000_0030;
    tick();
    fetch_en = 1'b0;
    chk("t8_ireq", 32'(ireq), 32'd1);
    rst = 1'b1; iack = 1'b1; inst_in = 32'h1234_5678;
    tick();
    rst = 1'b0; iack = 1'b0;
    chk("t8_ireq_rst", 32'(ireq), 32'd0);
    chk("t8_inst_rst", inst, 32'h0000_0013);
    chk("t8_inst_pc_rst", inst_pc, 32'h0);
    chk("t8_iaddr_rst", iaddr, 32'h0);
    chk("t8_valid_rst", 32'(inst_valid), 32'd0);
    chk("t8_busy_rst", 32'(busy), 32'd0);
    tick();
    chk("t8_idle_after", 32'(ireq), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
